// File: rtl/mac_pkg.sv
// Shared types for the MAC sequencer: FSM state encoding and default widths.
package mac_pkg;

    localparam int LEN_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mac_ld_pipe.sv
// PIPE_LAT-deep shift register that delays each operand pop into an
// accumulator load strobe; o_empty means nothing is pending after this edge.
module mac_ld_pipe #(
    parameter int PIPE_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_flush,
    output logic o_ld,
    output logic o_empty
);

    logic [PIPE_LAT-1:0] r_pipe;
    logic [PIPE_LAT-1:0] w_next;

    if (PIPE_LAT == 1) begin : g_one
        assign w_next = i_push;
    end else begin : g_multi
        assign w_next = {r_pipe[PIPE_LAT-2:0], i_push};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else if (i_flush) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_next;
        end
    end

    assign o_ld    = r_pipe[PIPE_LAT-1];
    assign o_empty = (w_next == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC run sequencer: clear, pop len operand pairs, drain load pipe, pulse done.
// Define MAC_SEQ_ABORT_EN to add the abort input.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W    = LEN_W_DEF,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_valid,
`ifdef MAC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             op_rd,
    output logic [LEN_W-1:0] addr,
    output logic             clr_acc,
    output logic             ld_out,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_addr;
    logic             r_clr;
    logic             r_busy;
    logic             r_done;
    logic             w_abort;
    logic             w_flush;
    logic             w_pop;
    logic             w_empty;

`ifdef MAC_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_flush = w_abort && (r_state == S_CLEAR || r_state == S_RUN ||
                                 r_state == S_DRAIN);
    // Pop is combinational on op_valid so a stalled source costs no cycle.
    assign w_pop   = (r_state == S_RUN) && op_valid && !w_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_addr  <= '0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            if (w_flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_addr <= '0;
                            r_busy <= 1'b1;
                            if (len != '0) begin
                                r_len   <= len;
                                r_state <= S_CLEAR;
                                r_clr   <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: r_state <= S_RUN;
                    S_RUN: begin
                        if (w_pop) begin
                            if (r_addr == r_len - LEN_W'(1)) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_addr <= r_addr + LEN_W'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    mac_ld_pipe #(
        .PIPE_LAT(PIPE_LAT)
    ) u_ld_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_pop),
        .i_flush(w_flush),
        .o_ld   (ld_out),
        .o_empty(w_empty)
    );

    assign op_rd   = w_pop;
    assign addr    = r_addr;
    assign clr_acc = r_clr;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: PIPE_LAT=1 and PIPE_LAT=3 instances,
// directed runs with hand-computed output events.
module tb_mac_seq_ctrl;

    typedef struct packed {
        int         cyc;
        logic       clr;
        logic       rd;
        logic       ld;
        logic       dn;
        logic [3:0] addr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [3:0] len_a, len_b;
    logic       val_a, val_b;
    logic       abort_a;
    logic       rd_a, clr_a, ld_a, busy_a, done_a;
    logic       rd_b, clr_b, ld_b, busy_b, done_b;
    logic [3:0] addr_a, addr_b;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_seq_ctrl #(.LEN_W(4), .PIPE_LAT(1)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .len     (len_a),
        .op_valid(val_a),
`ifdef MAC_SEQ_ABORT_EN
        .abort   (abort_a),
`endif
        .op_rd   (rd_a),
        .addr    (addr_a),
        .clr_acc (clr_a),
        .ld_out  (ld_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    mac_seq_ctrl #(.LEN_W(4), .PIPE_LAT(3)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .len     (len_b),
        .op_valid(val_b),
`ifdef MAC_SEQ_ABORT_EN
        .abort   (1'b0),
`endif
        .op_rd   (rd_b),
        .addr    (addr_b),
        .clr_acc (clr_b),
        .ld_out  (ld_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    function automatic ev_t mk(int c, bit clr, bit rd, int a, bit ld, bit dn);
        ev_t e;
        e.cyc  = c;
        e.clr  = clr;
        e.rd   = rd;
        e.ld   = ld;
        e.dn   = dn;
        e.addr = rd ? 4'(a) : 4'd0;
        return e;
    endfunction

    function automatic void pa(int c, bit clr, bit rd, int a, bit ld, bit dn);
        qa.push_back(mk(c, clr, rd, a, ld, dn));
    endfunction

    function automatic void pb(int c, bit clr, bit rd, int a, bit ld, bit dn);
        qb.push_back(mk(c, clr, rd, a, ld, dn));
    endfunction

    task automatic show(string nm, ev_t g, ev_t e);
        $display("FAIL %s got cyc=%0d clr=%0b rd=%0b addr=%0d ld=%0b done=%0b expected cyc=%0d clr=%0b rd=%0b addr=%0d ld=%0b done=%0b",
                 nm, g.cyc, g.clr, g.rd, g.addr, g.ld, g.dn,
                 e.cyc, e.clr, e.rd, e.addr, e.ld, e.dn);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h", nm, act, exp);
    endtask

    // Monitors: any strobe on a DUT output consumes one expected event.
    always begin
        ev_t g, e;
        @(negedge clk);
        #2;
        if (clr_a || rd_a || ld_a || done_a) begin
            g = mk(cyc, clr_a, rd_a, int'(addr_a), ld_a, done_a);
            n_chk++;
            if (qa.size() == 0) begin
                show("dut_a_unexpected", g, mk(0, 0, 0, 0, 0, 0));
            end else begin
                e = qa.pop_front();
                if (g === e) n_pass++;
                else show("dut_a_event", g, e);
            end
        end
    end

    always begin
        ev_t g, e;
        @(negedge clk);
        #2;
        if (clr_b || rd_b || ld_b || done_b) begin
            g = mk(cyc, clr_b, rd_b, int'(addr_b), ld_b, done_b);
            n_chk++;
            if (qb.size() == 0) begin
                show("dut_b_unexpected", g, mk(0, 0, 0, 0, 0, 0));
            end else begin
                e = qb.pop_front();
                if (g === e) n_pass++;
                else show("dut_b_event", g, e);
            end
        end
    end

    initial begin
        int c0;
        rst = 1'b1;
        start_a = 1'b0; len_a = '0; val_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; len_b = '0; val_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_a", {busy_a, done_a, rd_a, clr_a, ld_a, addr_a}, 32'd0);
        chk("reset_b", {busy_b, done_b, rd_b, clr_b, ld_b, addr_b}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // len=3, op_valid held high
        c0 = cyc;
        start_a = 1'b1; len_a = 4'd3; val_a = 1'b1;
        pa(c0 + 1, 1, 0, 0, 0, 0);
        pa(c0 + 2, 0, 1, 0, 0, 0);
        pa(c0 + 3, 0, 1, 1, 1, 0);
        pa(c0 + 4, 0, 1, 2, 1, 0);
        pa(c0 + 5, 0, 0, 0, 1, 0);
        pa(c0 + 6, 0, 0, 0, 0, 1);
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_in_clear", 32'(busy_a), 32'd1);
        repeat (7) @(negedge clk);
        chk("idle_after_len3", 32'(busy_a), 32'd0);

        // len=4, op_valid low every other cycle
        c0 = cyc;
        start_a = 1'b1; len_a = 4'd4; val_a = 1'b0;
        pa(c0 + 1, 1, 0, 0, 0, 0);
        pa(c0 + 2, 0, 1, 0, 0, 0);
        pa(c0 + 3, 0, 0, 0, 1, 0);
        pa(c0 + 4, 0, 1, 1, 0, 0);
        pa(c0 + 5, 0, 0, 0, 1, 0);
        pa(c0 + 6, 0, 1, 2, 0, 0);
        pa(c0 + 7, 0, 0, 0, 1, 0);
        pa(c0 + 8, 0, 1, 3, 0, 0);
        pa(c0 + 9, 0, 0, 0, 1, 0);
        pa(c0 + 10, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            val_a = (k % 2 == 0);
        end
        val_a = 1'b0;
        repeat (2) @(negedge clk);

        // len=0: straight to done
        c0 = cyc;
        start_a = 1'b1; len_a = 4'd0;
        pa(c0 + 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_len0_done", 32'(busy_a), 32'd1);
        repeat (3) @(negedge clk);

        // reset after the 2nd pop of a len=5 run
        c0 = cyc;
        start_a = 1'b1; len_a = 4'd5; val_a = 1'b1;
        pa(c0 + 1, 1, 0, 0, 0, 0);
        pa(c0 + 2, 0, 1, 0, 0, 0);
        pa(c0 + 3, 0, 1, 1, 1, 0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_mid_run", {busy_a, done_a, rd_a, clr_a, ld_a, addr_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_after_reset", {busy_a, addr_a}, 32'd0);
        end
        val_a = 1'b0;

        // start held across DONE restarts from IDLE
        c0 = cyc;
        start_a = 1'b1; len_a = 4'd1; val_a = 1'b1;
        pa(c0 + 1, 1, 0, 0, 0, 0);
        pa(c0 + 2, 0, 1, 0, 0, 0);
        pa(c0 + 3, 0, 0, 0, 1, 0);
        pa(c0 + 4, 0, 0, 0, 0, 1);
        pa(c0 + 6, 1, 0, 0, 0, 0);
        pa(c0 + 7, 0, 1, 0, 0, 0);
        pa(c0 + 8, 0, 0, 0, 1, 0);
        pa(c0 + 9, 0, 0, 0, 0, 1);
        repeat (5) @(negedge clk);
        chk("idle_between_runs", 32'(busy_a), 32'd0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        val_a = 1'b0;

        // PIPE_LAT=3, len=2
        c0 = cyc;
        start_b = 1'b1; len_b = 4'd2; val_b = 1'b1;
        pb(c0 + 1, 1, 0, 0, 0, 0);
        pb(c0 + 2, 0, 1, 0, 0, 0);
        pb(c0 + 3, 0, 1, 1, 0, 0);
        pb(c0 + 5, 0, 0, 0, 1, 0);
        pb(c0 + 6, 0, 0, 0, 1, 0);
        pb(c0 + 7, 0, 0, 0, 0, 1);
        @(negedge clk);
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain_busy_b", {busy_b, addr_b}, {27'd0, 1'b1, 4'd1});
        repeat (6) @(negedge clk);
        val_b = 1'b0;

`ifdef MAC_SEQ_ABORT_EN
        // abort during RUN of a len=6 run
        c0 = cyc;
        start_a = 1'b1; len_a = 4'd6; val_a = 1'b1;
        pa(c0 + 1, 1, 0, 0, 0, 0);
        pa(c0 + 2, 0, 1, 0, 0, 0);
        pa(c0 + 3, 0, 1, 1, 1, 0);
        pa(c0 + 4, 0, 0, 0, 1, 0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("idle_after_abort", 32'(busy_a), 32'd0);
        repeat (5) @(negedge clk);
        val_a = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("dut_a_events_left", 32'(qa.size()), 32'd0);
        chk("dut_b_events_left", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL take parameter LEN_W, default 4: width of the term-count and term-index fields.
REQ-002 SHALL take parameter PIPE_LAT, default 1, legal range 1..4: cycles from an operand pop to its product reaching the accumulator input.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a new MAC run; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W: number of terms in the run; captured when start is accepted.
REQ-007 SHALL have port op_valid, input, 1: operand source holds a valid operand pair.
REQ-008 SHALL have port op_rd, output, 1: pop one operand pair this cycle.
REQ-009 SHALL have port addr, output, LEN_W: index of the term being popped (0..len-1).
REQ-010 SHALL have port clr_acc, output, 1: clear the accumulator register.
REQ-011 SHALL have port ld_out, output, 1: load the accumulator register with the adder output.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: single-cycle pulse when the accumulated result is final.

Function
REQ-014 SHALL implement states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-015 SHALL, in IDLE with start=1 and len!=0, capture len, reset addr to 0 and go to CLEAR; with start=1 and len=0, go straight to DONE with no clr_acc, op_rd or ld_out.
REQ-016 SHALL assert clr_acc for exactly one cycle, in CLEAR, and then go to RUN.
REQ-017 SHALL, in RUN, drive op_rd = op_valid combinationally, and SHALL increment addr on each cycle with op_rd=1; op_valid=0 stalls without any state change.
REQ-018 SHALL leave RUN for DRAIN on the cycle after the pop with addr = len-1; addr then holds len-1.
REQ-019 SHALL assert ld_out exactly PIPE_LAT cycles after each op_rd cycle, giving exactly len ld_out pulses per run, with bubbles preserved.
REQ-020 SHALL remain in DRAIN until the ld_out delay pipe is empty, then enter DONE.
REQ-021 SHALL assert done for one cycle in DONE and return to IDLE on the next cycle.
REQ-022 SHALL ignore start outside IDLE; a start held high across DONE SHALL begin a new run from IDLE on the following cycle.
REQ-023 SHALL never assert clr_acc and ld_out in the same cycle.

Reset
REQ-024 SHALL, on rst, immediately force state IDLE, addr 0, the delay pipe empty, and op_rd, clr_acc, ld_out, busy and done all 0, including when reset arrives mid-run; no pending ld_out SHALL survive reset.

Configuration
REQ-025 SHALL, with MAC_SEQ_ABORT_EN defined, add port abort (input, 1); abort=1 in CLEAR, RUN or DRAIN SHALL go to IDLE on the next edge, with no further op_rd, flushed pending ld_out, and no done pulse.
REQ-026 SHALL, without MAC_SEQ_ABORT_EN, have no abort port and behave as REQ-014..023.

Structure
REQ-027 SHALL place the state encoding typedef and the LEN_W default in shared package mac_pkg.
REQ-028 SHALL implement the PIPE_LAT-deep ld_out shift register, with an empty flag, as sub-module mac_ld_pipe.

Verification
REQ-029 SHALL cover: len=3, op_valid held high, PIPE_LAT=1 -> clr_acc at cycle 1, op_rd at cycles 2-4 with addr 0,1,2, ld_out at cycles 3-5, done at cycle 6.
REQ-030 SHALL cover: len=4 with op_valid low every other cycle -> exactly 4 op_rd and 4 ld_out pulses, each ld_out 1 cycle after its op_rd, and done once.
REQ-031 SHALL cover: len=0 with start pulse -> done on the next cycle with no clr_acc, op_rd or ld_out.
REQ-032 SHALL cover: rst asserted after the 2nd op_rd of a len=5 run -> all outputs 0 immediately, no further ld_out, IDLE afterwards.
REQ-033 SHALL cover: PIPE_LAT=3, len=2 -> two ld_out pulses 3 cycles after their pops, DRAIN held until the pipe is empty, then done.
REQ-034 SHALL cover, with MAC_SEQ_ABORT_EN: abort in RUN of a len=6 run -> IDLE next cycle, no done, no ld_out after the flush.
